// File: rtl/logic_cell_checker_pkg.sv
// rtl/logic_cell_checker_pkg.sv - op encodings and checker FSM states
package logic_cell_checker_pkg;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NOTA = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETTLE = 2'b01,
    ST_CHECK  = 2'b10,
    ST_DONE   = 2'b11
  } state_t;

endpackage

// File: rtl/logic_golden.sv
// rtl/logic_golden.sv - golden bitwise logic unit: expected result for (a, b, sel)
module logic_golden
  import logic_cell_checker_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (sel)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NOTA: y = ~a;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/logic_cell_checker.sv
// rtl/logic_cell_checker.sv - sweeps every (a,b,S) vector through an external logic
// unit and checks its response against the golden model
module logic_cell_checker
  import logic_cell_checker_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 2,
  parameter int ERRW   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dut_out,
  output logic [WIDTH-1:0] dut_a,
  output logic [WIDTH-1:0] dut_b,
  output logic [1:0]       dut_S,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERRW-1:0]  err_count,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b,
  output logic [1:0]       fail_S,
  output logic [WIDTH-1:0] fail_out
);

  localparam int VW = 2 * WIDTH + 2;
  localparam int CW = $clog2(SETTLE + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);

  state_t           state, next_state;
  logic [VW-1:0]    vec;
  logic [CW-1:0]    cnt;
  logic             seen_fail;
  logic             start_sweep, cnt_inc, do_check;
  logic             vec_last, mismatch;
  logic [WIDTH-1:0] expected;

  // S varies fastest, then b, then a
  assign dut_a = vec[VW-1 -: WIDTH];
  assign dut_b = vec[WIDTH+1 -: WIDTH];
  assign dut_S = vec[1:0];

  assign vec_last = (vec == {VW{1'b1}});
  assign mismatch = (dut_out != expected);

  logic_golden #(.WIDTH(WIDTH)) u_golden (
    .a   (dut_a),
    .b   (dut_b),
    .sel (dut_S),
    .y   (expected)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state  = state;
    start_sweep = 1'b0;
    cnt_inc     = 1'b0;
    do_check    = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          start_sweep = 1'b1;
          next_state  = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        cnt_inc = 1'b1;
        if (cnt == CNT_LAST) next_state = ST_CHECK;
      end
      ST_CHECK: begin
        do_check   = 1'b1;
        next_state = vec_last ? ST_DONE : ST_SETTLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  assign busy = (state == ST_SETTLE) || (state == ST_CHECK);
  assign done = (state == ST_DONE);
  assign pass = done && (err_count == '0);

  always_ff @(posedge clk) begin
    if (reset || start_sweep) begin
      vec       <= '0;
      cnt       <= '0;
      err_count <= '0;
      seen_fail <= 1'b0;
      fail_a    <= '0;
      fail_b    <= '0;
      fail_S    <= '0;
      fail_out  <= '0;
    end else begin
      if (cnt_inc) cnt <= cnt + CW'(1);
      if (do_check) begin
        if (mismatch) begin
          if (err_count != {ERRW{1'b1}}) err_count <= err_count + ERRW'(1);
          // only the first failing vector is kept for diagnosis
          if (!seen_fail) begin
            seen_fail <= 1'b1;
            fail_a    <= dut_a;
            fail_b    <= dut_b;
            fail_S    <= dut_S;
            fail_out  <= dut_out;
          end
        end
        if (!vec_last) begin
          vec <= vec + VW'(1);
          cnt <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_logic_cell_checker.sv
// tb/tb_logic_cell_checker.sv - directed bench: correct, stuck-at-0 and OR/XOR-swapped
// unit models driven through three checker instances
module tb_logic_cell_checker;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // reference behaviour of the unit under test; mode 1 = stuck-at-0, 2 = OR/XOR swapped
  function automatic logic [3:0] model(input logic [3:0] a, input logic [3:0] b,
                                       input logic [1:0] s, input int mode);
    logic [1:0] op;
    logic [3:0] r;
    op = s;
    if (mode == 2 && s == 2'b01) op = 2'b10;
    else if (mode == 2 && s == 2'b10) op = 2'b01;
    case (op)
      2'b00:   r = a & b;
      2'b01:   r = a | b;
      2'b10:   r = a ^ b;
      default: r = ~a;
    endcase
    if (mode == 1) r = 4'd0;
    return r;
  endfunction

  int m1 = 0, m2 = 0, m3 = 0;

  logic       s1_start, s1_out, s1_a, s1_b, s1_busy, s1_done, s1_pass;
  logic [1:0] s1_S, s1_fS;
  logic [7:0] s1_err;
  logic       s1_fa, s1_fb, s1_fo;

  logic       s2_start, s2_out, s2_a, s2_b, s2_busy, s2_done, s2_pass;
  logic [1:0] s2_S, s2_fS, s2_err;
  logic       s2_fa, s2_fb, s2_fo;

  logic       s3_start, s3_busy, s3_done, s3_pass;
  logic [3:0] s3_out, s3_a, s3_b, s3_fa, s3_fb, s3_fo;
  logic [1:0] s3_S, s3_fS;
  logic [7:0] s3_err;

  logic [3:0] t1, t2;
  always_comb begin
    t1 = model({3'b0, s1_a}, {3'b0, s1_b}, s1_S, m1);
    t2 = model({3'b0, s2_a}, {3'b0, s2_b}, s2_S, m2);
    s1_out = t1[0];
    s2_out = t2[0];
    s3_out = model(s3_a, s3_b, s3_S, m3);
  end

  logic_cell_checker #(.WIDTH(1), .SETTLE(2), .ERRW(8)) u1 (
    .clk(clk), .reset(reset), .start(s1_start), .dut_out(s1_out),
    .dut_a(s1_a), .dut_b(s1_b), .dut_S(s1_S), .busy(s1_busy), .done(s1_done),
    .pass(s1_pass), .err_count(s1_err), .fail_a(s1_fa), .fail_b(s1_fb),
    .fail_S(s1_fS), .fail_out(s1_fo)
  );

  logic_cell_checker #(.WIDTH(1), .SETTLE(2), .ERRW(2)) u2 (
    .clk(clk), .reset(reset), .start(s2_start), .dut_out(s2_out),
    .dut_a(s2_a), .dut_b(s2_b), .dut_S(s2_S), .busy(s2_busy), .done(s2_done),
    .pass(s2_pass), .err_count(s2_err), .fail_a(s2_fa), .fail_b(s2_fb),
    .fail_S(s2_fS), .fail_out(s2_fo)
  );

  logic_cell_checker #(.WIDTH(4), .SETTLE(2), .ERRW(8)) u3 (
    .clk(clk), .reset(reset), .start(s3_start), .dut_out(s3_out),
    .dut_a(s3_a), .dut_b(s3_b), .dut_S(s3_S), .busy(s3_busy), .done(s3_done),
    .pass(s3_pass), .err_count(s3_err), .fail_a(s3_fa), .fail_b(s3_fb),
    .fail_S(s3_fS), .fail_out(s3_fo)
  );

  int cur = 1;
  logic        c_busy, c_done, c_pass;
  logic [31:0] c_err, c_vec, c_fail;
  always_comb begin
    c_busy = 1'b0; c_done = 1'b0; c_pass = 1'b0;
    c_err = '0; c_vec = '0; c_fail = '0;
    case (cur)
      1: begin
        c_busy = s1_busy; c_done = s1_done; c_pass = s1_pass; c_err = {24'd0, s1_err};
        c_vec = {28'd0, s1_a, s1_b, s1_S};
        c_fail = {27'd0, s1_fa, s1_fb, s1_fS, s1_fo};
      end
      2: begin
        c_busy = s2_busy; c_done = s2_done; c_pass = s2_pass; c_err = {30'd0, s2_err};
        c_vec = {28'd0, s2_a, s2_b, s2_S};
      end
      default: begin
        c_busy = s3_busy; c_done = s3_done; c_pass = s3_pass; c_err = {24'd0, s3_err};
        c_vec = {22'd0, s3_a, s3_b, s3_S};
      end
    endcase
  end

  task automatic set_start(input int sel, input logic v);
    if (sel == 1) s1_start = v;
    else if (sel == 2) s2_start = v;
    else s3_start = v;
  endtask

  // one start pulse on instance sel; optional extra start pulse mid-sweep
  task automatic sweep(input int sel, input int mid_k, output int cycles, output int busy_n,
                       output int order_err, output logic [31:0] first_done,
                       output logic [31:0] first_err, output logic [31:0] first_fail);
    cur = sel;
    @(negedge clk);
    set_start(sel, 1'b1);
    @(posedge clk);
    #1;
    set_start(sel, 1'b0);
    first_done = {31'd0, c_done};
    first_err  = c_err;
    first_fail = c_fail;
    busy_n     = c_busy ? 1 : 0;
    order_err  = (c_vec != 0) ? 1 : 0;
    cycles     = -1;
    for (int k = 1; k <= 4000; k++) begin
      @(posedge clk);
      #1;
      set_start(sel, 1'b0);
      if (c_done) begin
        cycles = k;
        break;
      end
      if (c_busy) busy_n++;
      if (c_vec != 32'(k / 3)) order_err++;
      if (k == mid_k) set_start(sel, 1'b1);
    end
  endtask

  int cyc, bn, oe;
  logic [31:0] fd, fe, ff;

  initial begin
    reset = 1'b1;
    s1_start = 1'b0; s2_start = 1'b0; s3_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, s1_busy}, 0);
    check("rst_done", {31'd0, s1_done}, 0);
    check("rst_pass", {31'd0, s1_pass}, 0);
    check("rst_err", {24'd0, s1_err}, 0);
    check("rst_vec", c_vec, 0);
    check("rst_fail", c_fail, 0);
    @(negedge clk);
    reset = 1'b0;

    // correct unit
    m1 = 0;
    sweep(1, 0, cyc, bn, oe, fd, fe, ff);
    check("t1_cycles", cyc, 48);
    check("t1_busy_cycles", bn, 48);
    check("t1_order", oe, 0);
    check("t1_done", {31'd0, s1_done}, 1);
    check("t1_pass", {31'd0, s1_pass}, 1);
    check("t1_err", {24'd0, s1_err}, 0);
    check("t1_hold_last", c_vec, 15);

    // stuck-at-0
    m1 = 1;
    sweep(1, 0, cyc, bn, oe, fd, fe, ff);
    check("t2_cycles", cyc, 48);
    check("t2_err", {24'd0, s1_err}, 8);
    check("t2_pass", {31'd0, s1_pass}, 0);
    check("t2_fail_a", {31'd0, s1_fa}, 0);
    check("t2_fail_b", {31'd0, s1_fb}, 0);
    check("t2_fail_S", {30'd0, s1_fS}, 3);
    check("t2_fail_out", {31'd0, s1_fo}, 0);

    // OR/XOR swapped; start from done clears the previous 8 errors
    m1 = 2;
    sweep(1, 0, cyc, bn, oe, fd, fe, ff);
    check("t3_restart_err", fe, 0);
    check("t3_err", {24'd0, s1_err}, 2);
    check("t3_fail_a", {31'd0, s1_fa}, 1);
    check("t3_fail_b", {31'd0, s1_fb}, 1);
    check("t3_fail_S", {30'd0, s1_fS}, 1);
    check("t3_fail_out", {31'd0, s1_fo}, 0);

    // restart from done with a correct unit
    m1 = 0;
    sweep(1, 0, cyc, bn, oe, fd, fe, ff);
    check("t6_done_drop", fd, 0);
    check("t6_err_clr", fe, 0);
    check("t6_fail_clr", ff, 0);
    check("t6_cycles", cyc, 48);
    check("t6_pass", {31'd0, s1_pass}, 1);

    // reset mid-sweep
    cur = 1;
    @(negedge clk);
    s1_start = 1'b1;
    @(posedge clk);
    #1;
    s1_start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    check("t4_busy_before", {31'd0, s1_busy}, 1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("t4_busy", {31'd0, s1_busy}, 0);
    check("t4_done", {31'd0, s1_done}, 0);
    check("t4_pass", {31'd0, s1_pass}, 0);
    check("t4_err", {24'd0, s1_err}, 0);
    check("t4_vec", c_vec, 0);
    @(negedge clk);
    reset = 1'b0;
    sweep(1, 0, cyc, bn, oe, fd, fe, ff);
    check("t4_cycles", cyc, 48);
    check("t4_pass_after", {31'd0, s1_pass}, 1);

    // start while busy ignored, 2-bit counter saturates
    m2 = 1;
    sweep(2, 10, cyc, bn, oe, fd, fe, ff);
    check("t5_cycles", cyc, 48);
    check("t5_order", oe, 0);
    check("t5_err_sat", {30'd0, s2_err}, 3);
    check("t5_pass", {31'd0, s2_pass}, 0);

    // WIDTH=4 correct unit
    m3 = 0;
    sweep(3, 0, cyc, bn, oe, fd, fe, ff);
    check("w4_cycles", cyc, 3072);
    check("w4_order", oe, 0);
    check("w4_pass", {31'd0, s3_pass}, 1);
    check("w4_err", {24'd0, s3_err}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
